// File: rtl/edge_det_pkg.sv
// Shared encodings and helpers for the multi-channel edge detector.
package edge_det_pkg;

  // Per-channel edge mode, bits [2n+1:2n] of mode_i
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Filter states; bit 1 of the STABLE codes equals the accepted level
  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'b00,
    ST_CHECK_HIGH  = 2'b01,
    ST_STABLE_HIGH = 2'b11,
    ST_CHECK_LOW   = 2'b10
  } filt_state_e;

  // The filter down-counter is loaded with FILT_CYCLES-2 on entry to a
  // CHECK state, so it only needs to hold values up to FILT_CYCLES-2.
  function automatic int filt_cnt_w(input int filt_cycles);
    if (filt_cycles <= 2) return 1;
    return $clog2(filt_cycles - 1);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One detector channel: synchroniser, debounce filter FSM, accepted level
// and mode-qualified event pulse.
//
// state          | meaning
// ---------------+------------------------------------------------------
// ST_STABLE_LOW  | accepted level 0, sample agrees
// ST_CHECK_HIGH  | sample went 1, counting down to accept a rising level
// ST_STABLE_HIGH | accepted level 1, sample agrees
// ST_CHECK_LOW   | sample went 0, counting down to accept a falling level
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal_i,
  input  logic [1:0] mode_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       event_o
);

  localparam int CW   = filt_cnt_w(FILT_CYCLES);
  localparam int LOAD = (FILT_CYCLES >= 2) ? FILT_CYCLES - 2 : 0;

  logic samp;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign samp = signal_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // shift chain: stage 0 takes the raw input
    always_comb begin
      sync_d[0] = signal_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign samp = sync_q[SYNC_STAGES-1];
  end

  filt_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          rise, fall;

  // filter next-state: a new level needs FILT_CYCLES identical samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise    = 1'b0;
    fall    = 1'b0;
    unique case (state_q)
      ST_STABLE_LOW: if (samp) begin
        if (FILT_CYCLES <= 1) begin
          state_d = ST_STABLE_HIGH;
          level_d = 1'b1;
          rise    = 1'b1;
        end else begin
          state_d = ST_CHECK_HIGH;
          cnt_d   = CW'(LOAD);
        end
      end
      ST_CHECK_HIGH: begin
        if (!samp) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_STABLE_HIGH;
          level_d = 1'b1;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STABLE_HIGH: if (!samp) begin
        if (FILT_CYCLES <= 1) begin
          state_d = ST_STABLE_LOW;
          level_d = 1'b0;
          fall    = 1'b1;
        end else begin
          state_d = ST_CHECK_LOW;
          cnt_d   = CW'(LOAD);
        end
      end
      ST_CHECK_LOW: begin
        if (samp) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_STABLE_LOW;
          level_d = 1'b0;
          fall    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // mode is looked at only on the accepting edge
  always_comb begin
    pulse_d = (rise && (mode_i == MODE_RISE || mode_i == MODE_BOTH)) ||
              (fall && (mode_i == MODE_FALL || mode_i == MODE_BOTH));
  end

  // filter state, level and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign event_o = pulse_d;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel detectors plus sticky
// pending/overflow flags and a registered interrupt.
// Optional per-channel saturating event counters: MULTI_EDGE_DETECTOR_CNT_EN.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     signal_i,
  input  logic [2*CH_NUM-1:0]   mode_i,
  input  logic [CH_NUM-1:0]     clr_i,
  output logic [CH_NUM-1:0]     level_o,
  output logic [CH_NUM-1:0]     pulse_o,
  output logic [CH_NUM-1:0]     pending_o,
  output logic [CH_NUM-1:0]     overflow_o,
`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  output logic [CH_NUM*CNT_W-1:0] event_cnt_o,
`endif
  output logic                  irq_o
);

  if (CH_NUM < 1 || SYNC_STAGES < 0 || FILT_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("multi_edge_detector: illegal parameter value");
  end

  logic [CH_NUM-1:0] event_w;

  for (genvar n = 0; n < CH_NUM; n++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .signal_i (signal_i[n]),
      .mode_i   (mode_i[2*n +: 2]),
      .level_o  (level_o[n]),
      .pulse_o  (pulse_o[n]),
      .event_o  (event_w[n])
    );
  end

  logic [CH_NUM-1:0] pending_q, pending_d;
  logic [CH_NUM-1:0] overflow_q, overflow_d;
  logic              irq_q, irq_d;

  // sticky flags; a new event beats a clear on the same edge
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int n = 0; n < CH_NUM; n++) begin
      if (event_w[n]) begin
        pending_d[n] = 1'b1;
        if (clr_i[n])          overflow_d[n] = 1'b0;
        else if (pending_q[n]) overflow_d[n] = 1'b1;
      end else if (clr_i[n]) begin
        pending_d[n]  = 1'b0;
        overflow_d[n] = 1'b0;
      end
    end
    irq_d = |pending_q;
  end

  // flag and interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign irq_o      = irq_q;

`ifdef MULTI_EDGE_DETECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_q [CH_NUM];
  logic [CNT_W-1:0] cnt_d [CH_NUM];

  // saturating event counters; clear with a coincident event loads 1
  always_comb begin
    for (int n = 0; n < CH_NUM; n++) begin
      cnt_d[n] = cnt_q[n];
      if (event_w[n] && clr_i[n])            cnt_d[n] = CNT_W'(1);
      else if (clr_i[n])                     cnt_d[n] = '0;
      else if (event_w[n] && !(&cnt_q[n]))   cnt_d[n] = cnt_q[n] + 1'b1;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CH_NUM; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < CH_NUM; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_cnt_out
    assign event_cnt_o[n*CNT_W +: CNT_W] = cnt_q[n];
  end
`endif

endmodule
